alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares a single combinational ALU between two requesters, such as the instruction-execute path and an address/DMA helper. It accepts operand/opcode requests over valid/ready handshakes and drives the ALU input bus. It captures the result and Z/N/C/V flags into a per-requester response register, then returns them over a second valid/ready handshake. It sits between the requesters and the ALU instance; the ALU itself is instantiated outside this block.

## Interface
- N, default 8: datapath width (operands, result).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_0 / req_valid_1  in  1  request present.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle when high together with valid.
- req_a_0, req_b_0 / req_a_1, req_b_1  in  N  operands.
- req_op_0 / req_op_1  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS; 6–7 illegal.
- rsp_valid_0 / rsp_valid_1  out  1  response register full.
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes response.
- rsp_y_0 / rsp_y_1  out  N  captured result.
- rsp_flags_0 / rsp_flags_1  out  4  captured {z,n,c,v}.
- rsp_err_0 / rsp_err_1  out  1  request carried an illegal opcode.
- alu_a, alu_b  out  N  ALU operands.
- alu_op  out  3  ALU opcode.
- alu_y  in  N  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_z, alu_n, alu_c, alu_v  in  1  ALU flags.
- op_count  out  16  number of accepted requests, wrapping.

## Operation
- Per-requester response slot: 2-state FSM, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_valid & rsp_ready with no accept in the same cycle.
  - FULL stays FULL, reloaded, when the response is consumed and a new request is accepted in the same cycle.
- Eligibility: requester i is eligible when req_valid_i & (~rsp_valid_i | rsp_ready_i).
- Grant: combinational, at most one requester per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one that is not last_grant is granted.
  - last_grant is a 1-bit register updated to the winner on every accept.
- req_ready_i = grant_i. Accept = req_valid_i & req_ready_i.
- ALU drive:
  - Granted with a legal op: alu_a/alu_b/alu_op = the winner's req_a/req_b/req_op.
  - No grant, or granted with an illegal op: alu_a=0, alu_b=0, alu_op=5 (PASS).
- Capture on accept:
  - Legal op: rsp_y_i←alu_y, rsp_flags_i←{alu_z,alu_n,alu_c,alu_v}, rsp_err_i←0.
  - Illegal op: rsp_y_i←0, rsp_flags_i←0, rsp_err_i←1.
- Response outputs hold stable while FULL and not consumed.
- op_count increments by 1 on each accept, illegal ops included; 0xFFFF+1→0x0000.
- Flag meanings are exactly those produced by the ALU:
  - C is carry-out for ADD and not-borrow (a≥b) for SUB.
  - C and V are 0 for logic ops and PASS.

## Timing
- Reset values:
  - rsp_valid_0/1=0, rsp_y=0, rsp_flags=0, rsp_err=0.
  - last_grant=1, so requester 0 wins the first tie.
  - op_count=0.
  - req_ready and alu_* follow combinationally from the reset state.
- Reset mid-operation: pending responses are discarded without handshake; reset takes effect asynchronously.
- Latency: request accepted at edge k gives rsp_valid=1 immediately after edge k (one cycle).
- Throughput: one accept per cycle in total.
  - Each requester is limited to one outstanding response.
  - Back-to-back accepts for one requester require rsp_ready held high.
- Combinational paths:
  - rsp_ready_i→req_ready_i.
  - req_*→alu_*→(external ALU)→capture.
  - The whole request-to-capture path must close in one cycle.
- req_ready does not depend on req_valid of the same port except through arbitration.
- Requesters must hold a/b/op stable while valid & ~ready.
- Simultaneous consume and accept on a port: the new result is captured and rsp_valid stays 1.

## Test plan
- Single request, req0 ADD 0x7F+0x01 → rsp_valid_0 one cycle after accept, rsp_y_0=0x80, flags z0 n1 c0 v1, op_count=1.
- Tie after reset, both valid with rsp_ready high:
  - req0 is granted first, req1 next cycle, then strict alternation.
  - alu_op idles at PASS with operands 0 when neither requester is valid.
- Backpressure, rsp_ready_0=0: req0 SUB 0x05−0x05 → rsp_y_0=0x00, flags z1 n0 c1 v0.
  - A second req0 sees req_ready_0=0 while req1 requests are granted every cycle.
  - Raising rsp_ready_0 accepts the pending req0 in that same cycle.
- Illegal op 6 on req1 → rsp_err_1=1, rsp_y_1=0, rsp_flags_1=0, alu_op=5 during the grant cycle, op_count increments.
- Reset asserted while rsp_valid_0=1 → rsp_valid_0 drops without a clock edge.
  - Post-reset SUB 0x00−0x01 returns y=0xFF, flags z0 n1 c0 v0.
- 65536 accepts from reset → op_count wraps to 0x0000.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bus between alu_arbiter, its two requesters and the external ALU.
// slave  : arbiter side (takes requests, rsp_ready and ALU results; drives ready, responses, ALU inputs, op_count)
// master : environment side (requesters plus ALU instance)
interface alu_arbiter_if #(parameter int N = 8);
  logic         req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [N-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [2:0]   req_op_0, req_op_1;
  logic         rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [N-1:0] rsp_y_0, rsp_y_1;
  logic [3:0]   rsp_flags_0, rsp_flags_1;
  logic         rsp_err_0, rsp_err_1;
  logic [N-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_op;
  logic         alu_z, alu_n, alu_c, alu_v;
  logic [15:0]  op_count;
  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_b_0, req_a_1, req_b_1, req_op_0, req_op_1,
           rsp_ready_0, rsp_ready_1, alu_y, alu_z, alu_n, alu_c, alu_v,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_y_0, rsp_y_1,
           rsp_flags_0, rsp_flags_1, rsp_err_0, rsp_err_1, alu_a, alu_b, alu_op, op_count
  );
  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_b_0, req_a_1, req_b_1, req_op_0, req_op_1,
           rsp_ready_0, rsp_ready_1, alu_y, alu_z, alu_n, alu_c, alu_v,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_y_0, rsp_y_1,
           rsp_flags_0, rsp_flags_1, rsp_err_0, rsp_err_1, alu_a, alu_b, alu_op, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one external combinational ALU between two requesters.
// clk, rst : clock and asynchronous active-high reset
// bus      : alu_arbiter_if.slave carrying both request/response handshakes, the ALU bus and op_count
module alu_arbiter #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} slot_t;
  slot_t st0, st1, nx0, nx1;
  logic last_grant, elig0, elig1, g0, g1, legal, drive;
  logic [N-1:0] win_a, win_b;
  logic [2:0] win_op;
  always_comb begin
    // a full slot can take a new request only when it is being drained this cycle
    elig0 = bus.req_valid_0 & ((st0 == EMPTY) | bus.rsp_ready_0);
    elig1 = bus.req_valid_1 & ((st1 == EMPTY) | bus.rsp_ready_1);
    g0 = elig0 & (~elig1 | last_grant);
    g1 = elig1 & (~elig0 | ~last_grant);
    win_a = g1 ? bus.req_a_1 : bus.req_a_0;
    win_b = g1 ? bus.req_b_1 : bus.req_b_0;
    win_op = g1 ? bus.req_op_1 : bus.req_op_0;
    legal = win_op <= 3'd5;
    drive = (g0 | g1) & legal;
    bus.req_ready_0 = g0;
    bus.req_ready_1 = g1;
    // idle or illegal: park the ALU on PASS of zero
    bus.alu_a = drive ? win_a : '0;
    bus.alu_b = drive ? win_b : '0;
    bus.alu_op = drive ? win_op : 3'd5;
    bus.rsp_valid_0 = st0 == FULL;
    bus.rsp_valid_1 = st1 == FULL;
    nx0 = g0 ? FULL : bus.rsp_ready_0 ? EMPTY : st0;
    nx1 = g1 ? FULL : bus.rsp_ready_1 ? EMPTY : st1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0 <= EMPTY;
      st1 <= EMPTY;
    end else begin
      st0 <= nx0;
      st1 <= nx1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      bus.op_count <= '0;
      bus.rsp_y_0 <= '0;
      bus.rsp_y_1 <= '0;
      bus.rsp_flags_0 <= '0;
      bus.rsp_flags_1 <= '0;
      bus.rsp_err_0 <= 1'b0;
      bus.rsp_err_1 <= 1'b0;
    end else begin
      if (g0 | g1) begin
        last_grant <= g1;
        bus.op_count <= bus.op_count + 16'd1;
      end
      if (g0) begin
        bus.rsp_y_0 <= legal ? bus.alu_y : '0;
        bus.rsp_flags_0 <= legal ? {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} : 4'd0;
        bus.rsp_err_0 <= ~legal;
      end
      if (g1) begin
        bus.rsp_y_1 <= legal ? bus.alu_y : '0;
        bus.rsp_flags_1 <= legal ? {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} : 4'd0;
        bus.rsp_err_1 <= ~legal;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU on the bus.
`timescale 1ns/1ps
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  logic [15:0] cnt;
  logic [11:0] alu_r;
  alu_arbiter_if #(.N(8)) bus();
  alu_arbiter #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [11:0] alu_model(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    logic [8:0] s;
    logic [7:0] y;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = 9'd0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      3'd1: begin
        y = a - b;
        c = a >= b;
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      default: y = a;
    endcase
    return {y == 8'd0, y[7], c, v, y};
  endfunction
  function automatic logic [12:0] expect_rsp(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    return (op > 3'd5) ? 13'h1000 : {1'b0, alu_model(a, b, op)};
  endfunction
  always_comb begin
    alu_r = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
    bus.alu_y = alu_r[7:0];
    {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} = alu_r[11:8];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    cyc();
    rst = 1'b0;
  endtask
  task automatic rnd0();
    bus.req_a_0 = 8'($urandom);
    bus.req_b_0 = 8'($urandom);
    bus.req_op_0 = 3'($urandom_range(0, 7));
  endtask
  task automatic rnd1();
    bus.req_a_1 = 8'($urandom);
    bus.req_b_1 = 8'($urandom);
    bus.req_op_1 = 3'($urandom_range(0, 7));
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_grant", {31'd0, bus.req_ready_0 & bus.req_ready_1}, 0);
      if (bus.rsp_valid_0 && bus.rsp_ready_0) begin
        if (q0.size() == 0) chk("rsp0_queue", q0.size(), 1);
        else chk("rsp0", {19'd0, bus.rsp_err_0, bus.rsp_flags_0, bus.rsp_y_0}, {19'd0, q0.pop_front()});
      end
      if (bus.rsp_valid_1 && bus.rsp_ready_1) begin
        if (q1.size() == 0) chk("rsp1_queue", q1.size(), 1);
        else chk("rsp1", {19'd0, bus.rsp_err_1, bus.rsp_flags_1, bus.rsp_y_1}, {19'd0, q1.pop_front()});
      end
      if (bus.req_valid_0 && bus.req_ready_0) begin
        q0.push_back(expect_rsp(bus.req_a_0, bus.req_b_0, bus.req_op_0));
        chk("route0", {13'd0, bus.alu_op, bus.alu_a, bus.alu_b},
            bus.req_op_0 > 3'd5 ? {13'd0, 3'd5, 16'd0} : {13'd0, bus.req_op_0, bus.req_a_0, bus.req_b_0});
      end
      if (bus.req_valid_1 && bus.req_ready_1) begin
        q1.push_back(expect_rsp(bus.req_a_1, bus.req_b_1, bus.req_op_1));
        chk("route1", {13'd0, bus.alu_op, bus.alu_a, bus.alu_b},
            bus.req_op_1 > 3'd5 ? {13'd0, 3'd5, 16'd0} : {13'd0, bus.req_op_1, bus.req_a_1, bus.req_b_1});
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    {bus.req_valid_0, bus.req_valid_1, bus.rsp_ready_0, bus.rsp_ready_1} = '0;
    {bus.req_a_0, bus.req_b_0, bus.req_a_1, bus.req_b_1} = '0;
    bus.req_op_0 = 3'd0;
    bus.req_op_1 = 3'd0;
    cyc();
    chk("rst_valid", {bus.rsp_valid_1, bus.rsp_valid_0}, 0);
    chk("rst_count", bus.op_count, 0);
    chk("rst_rsp", {bus.rsp_err_1, bus.rsp_flags_1, bus.rsp_y_1, bus.rsp_err_0, bus.rsp_flags_0, bus.rsp_y_0}, 0);
    chk("rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'd5, 16'd0});
    cyc();
    rst = 1'b0;
    // single ADD 0x7F + 0x01
    bus.req_valid_0 = 1'b1;
    bus.req_a_0 = 8'h7F;
    bus.req_b_0 = 8'h01;
    bus.req_op_0 = 3'd0;
    #1 chk("add_ready", bus.req_ready_0, 1);
    cyc();
    bus.req_valid_0 = 1'b0;
    chk("add_valid", bus.rsp_valid_0, 1);
    chk("add_y", bus.rsp_y_0, 8'h80);
    chk("add_flags", bus.rsp_flags_0, 4'b0101);
    chk("add_count", bus.op_count, 1);
    bus.rsp_ready_0 = 1'b1;
    cyc();
    bus.rsp_ready_0 = 1'b0;
    chk("add_drained", bus.rsp_valid_0, 0);
    // tie after reset: req0 first, then strict alternation
    do_reset();
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    rnd0();
    rnd1();
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("tie_r0", bus.req_ready_0, (k % 2) == 0);
      chk("tie_r1", bus.req_ready_1, (k % 2) == 1);
      cyc();
      if (k % 2 == 0) rnd0();
      else rnd1();
    end
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    #1 chk("idle_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'd5, 16'd0});
    cyc();
    // backpressure on port 0
    bus.rsp_ready_0 = 1'b0;
    bus.req_valid_0 = 1'b1;
    bus.req_a_0 = 8'h05;
    bus.req_b_0 = 8'h05;
    bus.req_op_0 = 3'd1;
    cyc();
    chk("sub_y", bus.rsp_y_0, 8'h00);
    chk("sub_flags", bus.rsp_flags_0, 4'b1010);
    bus.req_a_0 = 8'h03;
    bus.req_b_0 = 8'h04;
    bus.req_op_0 = 3'd0;
    bus.req_valid_1 = 1'b1;
    rnd1();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_r0", bus.req_ready_0, 0);
      chk("bp_r1", bus.req_ready_1, 1);
      cyc();
      rnd1();
    end
    bus.rsp_ready_0 = 1'b1;
    #1;
    chk("bp_release_r0", bus.req_ready_0, 1);
    chk("bp_release_r1", bus.req_ready_1, 0);
    cyc();
    bus.req_valid_0 = 1'b0;
    #1 chk("bp_next_r1", bus.req_ready_1, 1);
    cyc();
    bus.req_valid_1 = 1'b0;
    cyc();
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    // illegal opcode on port 1
    bus.req_valid_1 = 1'b1;
    bus.req_a_1 = 8'h12;
    bus.req_b_1 = 8'h34;
    bus.req_op_1 = 3'd6;
    cnt = bus.op_count;
    #1;
    chk("ill_ready", bus.req_ready_1, 1);
    chk("ill_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'd5, 16'd0});
    cyc();
    bus.req_valid_1 = 1'b0;
    chk("ill_err", bus.rsp_err_1, 1);
    chk("ill_y_flags", {bus.rsp_flags_1, bus.rsp_y_1}, 0);
    chk("ill_count", bus.op_count, {16'd0, cnt} + 1);
    bus.rsp_ready_1 = 1'b1;
    cyc();
    bus.rsp_ready_1 = 1'b0;
    // asynchronous reset with a pending response
    bus.req_valid_0 = 1'b1;
    bus.req_a_0 = 8'h01;
    bus.req_b_0 = 8'h01;
    bus.req_op_0 = 3'd0;
    cyc();
    bus.req_valid_0 = 1'b0;
    chk("pend_valid", bus.rsp_valid_0, 1);
    #2;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("async_valid", bus.rsp_valid_0, 0);
    chk("async_count", bus.op_count, 0);
    cyc();
    rst = 1'b0;
    bus.req_valid_0 = 1'b1;
    bus.req_a_0 = 8'h00;
    bus.req_b_0 = 8'h01;
    bus.req_op_0 = 3'd1;
    cyc();
    bus.req_valid_0 = 1'b0;
    chk("post_y", bus.rsp_y_0, 8'hFF);
    chk("post_flags", bus.rsp_flags_0, 4'b0100);
    bus.rsp_ready_0 = 1'b1;
    cyc();
    // op_count wrap after 65536 accepts
    do_reset();
    bus.req_valid_0 = 1'b1;
    bus.req_a_0 = 8'h5A;
    bus.req_b_0 = 8'h00;
    bus.req_op_0 = 3'd5;
    repeat (65535) cyc();
    chk("count_ffff", bus.op_count, 16'hFFFF);
    cyc();
    chk("count_wrap", bus.op_count, 0);
    bus.req_valid_0 = 1'b0;
    cyc();
    bus.rsp_ready_0 = 1'b0;
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
